// File: rtl/prog_mem_controller_pkg.sv
// rtl/prog_mem_controller_pkg.sv - shared controller state encodings and sizing helper
//
// Purpose: single home for the fetch-controller state encodings (CTRL_IDLE,
// CTRL_REQUEST, CTRL_RESPOND) and the channel-index width helper used by the
// controller and its arbiter.
// Ports: none (package).
package prog_mem_controller_pkg;

  // Controller state encodings; kept here so every block agrees on the values.
  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_REQUEST = 2'd1,
    CTRL_RESPOND = 2'd2
  } ctrl_state_e;

  // Width of a channel index; a single-channel build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_mem_controller_if.sv
// rtl/prog_mem_controller_if.sv - consumer fetch and backing-memory signal bundle
//
// Purpose: groups the per-channel consumer fetch port and the backing program
// memory port of prog_mem_controller.
// Signals:
//   consumer_read_valid [NUM_CHANNELS]        per-channel fetch request, held until acked
//   consumer_read_addr  [NUM_CHANNELS*AW]     per-channel address, channel i at slice i
//   consumer_read_ack   [NUM_CHANNELS]        per-channel one-cycle completion pulse
//   consumer_read_data  [NUM_CHANNELS*IW]     per-channel instruction, valid with ack
//   mem_read_valid / mem_read_addr            request to backing memory
//   mem_read_ready / mem_read_data            backing memory completion and data
// Modports: master = controller view, slave = consumers plus memory view.
interface prog_mem_controller_if #(
  parameter int NUM_CHANNELS           = 4,
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  parameter int INSTRUCTION_WIDTH      = 32
);

  logic [NUM_CHANNELS-1:0]                        consumer_read_valid;
  logic [NUM_CHANNELS*PROGRAM_MEM_ADDR_WIDTH-1:0] consumer_read_addr;
  logic [NUM_CHANNELS-1:0]                        consumer_read_ack;
  logic [NUM_CHANNELS*INSTRUCTION_WIDTH-1:0]      consumer_read_data;
  logic                                           mem_read_valid;
  logic [PROGRAM_MEM_ADDR_WIDTH-1:0]              mem_read_addr;
  logic                                           mem_read_ready;
  logic [INSTRUCTION_WIDTH-1:0]                   mem_read_data;

  modport master (
    input  consumer_read_valid, consumer_read_addr, mem_read_ready, mem_read_data,
    output consumer_read_ack, consumer_read_data, mem_read_valid, mem_read_addr
  );

  modport slave (
    output consumer_read_valid, consumer_read_addr, mem_read_ready, mem_read_data,
    input  consumer_read_ack, consumer_read_data, mem_read_valid, mem_read_addr
  );

endinterface

// File: rtl/prog_mem_controller_rr_arbiter.sv
// rtl/prog_mem_controller_rr_arbiter.sv - combinational round-robin arbiter (module rr_arbiter)
//
// Purpose: picks one requesting channel, searching upward from last_grant+1
// (mod NUM_CHANNELS) so the most recently served channel has lowest priority.
// Ports:
//   req         in  [NUM_CHANNELS]  request vector
//   last_grant  in  [IDX_W]         index of the channel served most recently
//   grant       out [NUM_CHANNELS]  one-hot grant (all zero when no request)
//   grant_idx   out [IDX_W]         index of the granted channel
//   grant_valid out                 any request present
module rr_arbiter
  import prog_mem_controller_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int IDX_W       = idx_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]        last_grant,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // k runs 1..N so last_grant itself is examined last.
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CHANNELS);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_mem_controller.sv
// rtl/prog_mem_controller.sv - multi-channel program memory fetch controller
//
// Purpose: serves NUM_CHANNELS instruction fetch channels from one backing
// program memory, one transaction at a time, with round-robin channel choice.
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    prog_mem_controller_if.master: consumer fetch port and memory port
// Build option: define PROG_MEM_LINE_BUF_EN to add a single-entry line buffer
// holding the last fetched address/instruction; a grant hitting it is answered
// without a memory read.
module prog_mem_controller
  import prog_mem_controller_pkg::*;
#(
  parameter int NUM_CHANNELS           = 4,
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  parameter int INSTRUCTION_WIDTH      = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  prog_mem_controller_if.master  bus
);

  localparam int IDX_W = idx_width(NUM_CHANNELS);
  localparam int AW    = PROGRAM_MEM_ADDR_WIDTH;
  localparam int IW    = INSTRUCTION_WIDTH;

  ctrl_state_e             state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q;
  logic [IDX_W-1:0]        grant_q;
  logic                    mem_valid_q;
  logic [AW-1:0]           mem_addr_q;
  logic [NUM_CHANNELS-1:0] ack_q;
  logic [NUM_CHANNELS*IW-1:0] data_q;

  logic [NUM_CHANNELS-1:0] arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic [AW-1:0]           sel_addr;
  logic                    buf_hit;
  logic [IW-1:0]           hit_data;
  logic                    grant_fire;
  logic                    capture_fire;
  logic                    respond_fire;

  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_rr_arbiter (
    .req         (bus.consumer_read_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Address of the channel the arbiter is offering this cycle.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (arb_grant[i]) begin
        sel_addr = bus.consumer_read_addr[i*AW +: AW];
      end
    end
  end

`ifdef PROG_MEM_LINE_BUF_EN
  logic          lb_valid_q;
  logic [AW-1:0] lb_addr_q;
  logic [IW-1:0] lb_data_q;

  assign buf_hit  = lb_valid_q && (lb_addr_q == sel_addr);
  assign hit_data = lb_data_q;

  // Every memory completion refills the entry; hits never change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_valid_q <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else if (capture_fire) begin
      lb_valid_q <= 1'b1;
      lb_addr_q  <= mem_addr_q;
      lb_data_q  <= bus.mem_read_data;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_fire   = 1'b0;
    capture_fire = 1'b0;
    respond_fire = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (arb_valid) begin
          grant_fire = 1'b1;
          state_d    = buf_hit ? CTRL_RESPOND : CTRL_REQUEST;
        end
      end
      CTRL_REQUEST: begin
        // mem_read_ready only matters here; elsewhere it is ignored.
        if (bus.mem_read_ready) begin
          capture_fire = 1'b1;
          state_d      = CTRL_RESPOND;
        end
      end
      CTRL_RESPOND: begin
        respond_fire = 1'b1;
        state_d      = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // ack_q is set on the edge entering CTRL_RESPOND, so it is high exactly
  // during the respond cycle and cleared on the way back to CTRL_IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CTRL_IDLE;
      last_grant_q <= IDX_W'(NUM_CHANNELS - 1);
      grant_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      ack_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        grant_q    <= arb_idx;
        mem_addr_q <= sel_addr;
        if (buf_hit) begin
          ack_q[arb_idx]               <= 1'b1;
          data_q[arb_idx*IW +: IW]     <= hit_data;
        end else begin
          mem_valid_q <= 1'b1;
        end
      end
      if (capture_fire) begin
        mem_valid_q                  <= 1'b0;
        ack_q[grant_q]               <= 1'b1;
        data_q[grant_q*IW +: IW]     <= bus.mem_read_data;
      end
      if (respond_fire) begin
        ack_q        <= '0;
        last_grant_q <= grant_q;
      end
    end
  end

  assign bus.consumer_read_ack  = ack_q;
  assign bus.consumer_read_data = data_q;
  assign bus.mem_read_valid     = mem_valid_q;
  assign bus.mem_read_addr      = mem_addr_q;

endmodule

// File: doc/prog_mem_controller.md
PROG_MEM_CONTROLLER -- requirements
Module: prog_mem_controller

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of fetch channels served, range 1..8.
REQ-002 Parameter PROGRAM_MEM_ADDR_WIDTH, default 6: instruction address width.
REQ-003 Parameter INSTRUCTION_WIDTH, default 32: instruction word width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port consumer_read_valid  input  NUM_CHANNELS  per-channel fetch request, held until acked.
REQ-007 Port consumer_read_addr  input  NUM_CHANNELS*PROGRAM_MEM_ADDR_WIDTH  per-channel address, channel i at slice i.
REQ-008 Port consumer_read_ack  output  NUM_CHANNELS  per-channel one-cycle completion pulse.
REQ-009 Port consumer_read_data  output  NUM_CHANNELS*INSTRUCTION_WIDTH  per-channel instruction; valid while matching ack is high.
REQ-010 Port mem_read_valid  output  1  request to backing program memory.
REQ-011 Port mem_read_addr  output  PROGRAM_MEM_ADDR_WIDTH  backing memory address.
REQ-012 Port mem_read_ready  input  1  backing memory returns data this cycle.
REQ-013 Port mem_read_data  input  INSTRUCTION_WIDTH  backing memory data, sampled when mem_read_ready=1.

Function
REQ-014 Controller SHALL implement three states: CTRL_IDLE, CTRL_REQUEST, CTRL_RESPOND.
REQ-015 CTRL_IDLE: if any consumer_read_valid bit set, SHALL grant one channel round-robin starting at (last_grant+1) mod NUM_CHANNELS, latch its address, drive mem_read_valid=1, mem_read_addr=latched address, go CTRL_REQUEST.
REQ-016 CTRL_REQUEST: mem_read_valid and mem_read_addr SHALL hold stable until mem_read_ready=1; on that edge capture mem_read_data, drop mem_read_valid, go CTRL_RESPOND.
REQ-017 CTRL_RESPOND: SHALL assert consumer_read_ack[grant] for exactly one cycle with captured data on that channel's slice, update last_grant, return CTRL_IDLE.
REQ-018 At most one ack bit SHALL be high in any cycle; non-granted data slices SHALL hold their last value.
REQ-019 Minimum request-to-ack latency SHALL be 3 cycles (grant, memory ready same cycle, respond); each extra memory wait cycle adds one.
REQ-020 A channel deasserting valid while granted SHALL NOT abort the transaction; ack is still issued once.
REQ-021 A channel whose valid is low in CTRL_IDLE SHALL be skipped; a new request from the just-acked channel SHALL NOT be granted ahead of other pending channels.
REQ-022 mem_read_ready while not in CTRL_REQUEST SHALL be ignored.

Reset
REQ-023 On rst_n=0 (asynchronous): state=CTRL_IDLE, last_grant=NUM_CHANNELS-1, mem_read_valid=0, mem_read_addr=0, consumer_read_ack=0, consumer_read_data=0, line buffer (if present) invalid.
REQ-024 Reset mid-transaction SHALL discard the transaction with no ack; after release operation resumes from CTRL_IDLE.

Configuration
REQ-025 Macro PROG_MEM_LINE_BUF_EN defined: single-entry buffer holds last fetched address/instruction; grant in CTRL_IDLE whose address matches a valid entry SHALL skip CTRL_REQUEST and go directly to CTRL_RESPOND with buffered data (2-cycle latency, mem_read_valid stays 0); every memory completion refills the entry.
REQ-026 Macro undefined: no buffer; every grant goes through CTRL_REQUEST.

Structure
REQ-027 State encodings CTRL_IDLE/CTRL_REQUEST/CTRL_RESPOND SHALL be defines in the shared common_defs file alongside existing FETCHER_/SIMD_ state defines.
REQ-028 Round-robin arbiter SHALL be one sub-module rr_arbiter (request vector, last_grant in; one-hot grant and index out, combinational).

Verification
REQ-029 Single request: ch0 valid, addr 5, memory ready 1 cycle after mem_read_valid, data 0xDEADBEEF -> ack[0] one pulse with 0xDEADBEEF, 4 cycles after valid.
REQ-030 Contention: ch0..ch3 valid simultaneously after reset, zero-wait memory -> acks in order 0,1,2,3, never two ack bits high.
REQ-031 Fairness: ch1 re-requests immediately after each ack while ch2 pending -> ch2 acked before ch1's second ack.
REQ-032 Stall: mem_read_ready held low 10 cycles -> mem_read_valid and mem_read_addr stable throughout, ack follows ready by 1 cycle.
REQ-033 Reset mid-transaction: rst_n low during CTRL_REQUEST -> mem_read_valid=0 immediately, no ack, next request served normally.
REQ-034 With PROG_MEM_LINE_BUF_EN: two consecutive fetches of addr 7 -> second acked in 2 cycles with mem_read_valid never asserted; without macro -> second issues a memory read.
